// File: rtl/fx_gain_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fx_gain_scheduler
//  Function : Per-frame stereo gain/mute stage sharing one signed 16x16
//             multiplier across both channels; gain updates at frame start.
//  Revision : 1.0 - initial release
// ============================================================================
module fx_gain_scheduler #(
    parameter int          FRAC_BITS    = 14,
    parameter logic [15:0] DEFAULT_GAIN = 16'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        VALID,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        mute,
    input  logic        gain_wr,
    input  logic [15:0] gain_data,
    output logic        gain_ack,
    input  logic        clr_ovr,
    output logic [15:0] left_out,
    output logic [15:0] right_out,
    output logic        out_vld,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL_L = 2'd1,
        ST_MUL_R = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic signed [15:0] r_l_s;
    logic signed [15:0] r_r_s;
    logic signed [15:0] r_eff_gain;
    logic signed [15:0] r_l_res;
    logic signed [31:0] r_prod;
    logic        [15:0] r_active_gain;
    logic        [15:0] r_pending_gain;
    logic               r_pending;

    logic               w_start;
    logic signed [15:0] w_mul_a;
    logic signed [31:0] w_prod;
    logic signed [15:0] w_sat;

    // Floor shift (arithmetic) then clamp to the signed 16-bit range.
    function automatic logic signed [15:0] sat(input logic signed [31:0] p);
        logic signed [31:0] s;
        s = p >>> FRAC_BITS;
        if (s > 32'sd32767)
            return 16'sh7FFF;
        else if (s < -32'sd32768)
            return 16'sh8000;
        else
            return s[15:0];
    endfunction

    assign w_start = (r_state == ST_IDLE) && VALID;
    assign busy    = (r_state != ST_IDLE);
    assign w_mul_a = (r_state == ST_MUL_L) ? r_l_s : r_r_s;
    assign w_prod  = 32'(w_mul_a) * 32'(r_eff_gain);
    assign w_sat   = sat(r_prod);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (VALID) w_next_state = ST_MUL_L;
            ST_MUL_L: w_next_state = ST_MUL_R;
            ST_MUL_R: w_next_state = ST_OUT;
            ST_OUT:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_l_s          <= '0;
            r_r_s          <= '0;
            r_eff_gain     <= '0;
            r_l_res        <= '0;
            r_prod         <= '0;
            r_active_gain  <= DEFAULT_GAIN;
            r_pending_gain <= '0;
            r_pending      <= 1'b0;
            gain_ack       <= 1'b0;
            left_out       <= '0;
            right_out      <= '0;
            out_vld        <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            gain_ack <= 1'b0;
            out_vld  <= 1'b0;

            if (w_start) begin
                r_l_s      <= left_in;
                r_r_s      <= right_in;
                r_eff_gain <= mute ? 16'sd0
                            : (r_pending ? r_pending_gain : r_active_gain);
                if (r_pending) begin
                    r_active_gain <= r_pending_gain;
                    r_pending     <= 1'b0;
                    gain_ack      <= 1'b1;
                end
            end

            // A write on the frame-start edge stays pending for the next frame.
            if (gain_wr) begin
                r_pending_gain <= gain_data;
                r_pending      <= 1'b1;
            end

            if (VALID && busy)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;

            case (r_state)
                ST_MUL_L: r_prod <= w_prod;
                ST_MUL_R: begin
                    r_l_res <= w_sat;
                    r_prod  <= w_prod;
                end
                ST_OUT: begin
                    left_out  <= r_l_res;
                    right_out <= w_sat;
                    out_vld   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fx_gain_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fx_gain_scheduler
//  Function : Self-checking bench for fx_gain_scheduler against an
//             arithmetic reference model of frames and the gain handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fx_gain_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        VALID;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        mute;
    logic        gain_wr;
    logic [15:0] gain_data;
    logic        gain_ack;
    logic        clr_ovr;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        out_vld;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    // Reference gain state
    logic [15:0] m_ag;
    logic [15:0] m_pg;
    logic        m_pend;
    logic [15:0] m_lo;
    logic [15:0] m_ro;

    fx_gain_scheduler #(
        .FRAC_BITS   (14),
        .DEFAULT_GAIN(16'h4000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .VALID    (VALID),
        .left_in  (left_in),
        .right_in (right_in),
        .mute     (mute),
        .gain_wr  (gain_wr),
        .gain_data(gain_data),
        .gain_ack (gain_ack),
        .clr_ovr  (clr_ovr),
        .left_out (left_out),
        .right_out(right_out),
        .out_vld  (out_vld),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // sample * gain / 2^14 rounded toward minus infinity, clamped to 16 bits.
    function automatic logic [15:0] ref_scale(input logic [15:0] s, input logic [15:0] g);
        longint p;
        longint q;
        p = longint'($signed(s)) * longint'($signed(g));
        q = p / 16384;
        if (p < 0 && (p % 16384) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic gain_write(input logic [15:0] d);
        gain_wr   = 1'b1;
        gain_data = d;
        tick();
        gain_wr   = 1'b0;
        m_pg      = d;
        m_pend    = 1'b1;
        check1("ack_no_frame", gain_ack, 1'b0);
    endtask

    task automatic model_reset();
        m_ag   = 16'h4000;
        m_pg   = 16'h0000;
        m_pend = 1'b0;
        m_lo   = 16'h0000;
        m_ro   = 16'h0000;
    endtask

    // One full frame; optional same-edge gain write and overrun injection
    // (with a simultaneous clr_ovr, which must lose).
    task automatic do_frame(input logic [15:0] l, input logic [15:0] r, input logic m,
                            input logic wr_same, input logic [15:0] wr_d, input logic inj_ovr);
        logic [15:0] eff;
        logic        ack_exp;
        eff     = m ? 16'h0000 : (m_pend ? m_pg : m_ag);
        ack_exp = m_pend;
        if (m_pend) begin
            m_ag   = m_pg;
            m_pend = 1'b0;
        end
        if (wr_same) begin
            m_pg   = wr_d;
            m_pend = 1'b1;
        end
        m_lo = ref_scale(l, eff);
        m_ro = ref_scale(r, eff);

        VALID = 1'b1; left_in = l; right_in = r; mute = m;
        gain_wr = wr_same; gain_data = wr_d;
        tick();                                      // E0
        VALID = 1'b0; gain_wr = 1'b0; mute = 1'b0;
        left_in = 16'($urandom); right_in = 16'($urandom);
        check1("gain_ack", gain_ack, ack_exp);
        check1("busy_run", busy, 1'b1);
        check1("vld_early", out_vld, 1'b0);
        tick();                                      // E1
        if (inj_ovr) begin
            VALID = 1'b1; clr_ovr = 1'b1;
            left_in = 16'h7FFF; right_in = 16'h7FFF; mute = 1'b1;
        end
        tick();                                      // E2
        VALID = 1'b0; clr_ovr = 1'b0; mute = 1'b0;
        if (inj_ovr) check1("ovr_set", overrun, 1'b1);
        check1("ack_low", gain_ack, 1'b0);
        check1("vld_mid", out_vld, 1'b0);
        tick();                                      // E3
        check1("out_vld", out_vld, 1'b1);
        check16("left_out", left_out, m_lo);
        check16("right_out", right_out, m_ro);
        tick();
        check1("vld_pulse", out_vld, 1'b0);
        check1("busy_idle", busy, 1'b0);
        check16("left_hold", left_out, m_lo);
        check16("right_hold", right_out, m_ro);
    endtask

    initial begin
        rst_n = 1'b0; VALID = 1'b0; left_in = '0; right_in = '0; mute = 1'b0;
        gain_wr = 1'b0; gain_data = '0; clr_ovr = 1'b0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        check16("rst_left", left_out, 16'h0000);
        check16("rst_right", right_out, 16'h0000);
        check1("rst_vld", out_vld, 1'b0);
        check1("rst_ack", gain_ack, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ovr", overrun, 1'b0);

        // Default gain passes samples through
        do_frame(16'h1234, 16'hFEDC, 1'b0, 1'b0, 16'h0, 1'b0);
        // Saturation at both rails
        gain_write(16'h7FFF);
        do_frame(16'h5000, 16'hB000, 1'b0, 1'b0, 16'h0, 1'b0);
        // Floor behaviour on both signs
        gain_write(16'h2000);
        do_frame(16'h0003, 16'hFFFD, 1'b0, 1'b0, 16'h0, 1'b0);
        // Last write wins; same-edge write deferred to the next frame
        gain_write(16'h1000);
        gain_write(16'h4000);
        do_frame(16'h1111, 16'hE000, 1'b0, 1'b1, 16'h2000, 1'b0);
        do_frame(16'h4000, 16'hC000, 1'b0, 1'b0, 16'h0, 1'b0);
        // Mute latched at frame start only
        do_frame(16'h7000, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0);
        // Overrun during MUL_R; frame unaffected; set beats clear
        do_frame(16'h0100, 16'hFF00, 1'b0, 1'b0, 16'h0, 1'b1);
        check1("ovr_sticky", overrun, 1'b1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check1("ovr_clear", overrun, 1'b0);

        // Reset during MUL_L with a pending gain
        gain_write(16'h1000);
        VALID = 1'b1; left_in = 16'h2222; right_in = 16'h3333;
        tick();
        VALID = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            check1("abort_vld", out_vld, 1'b0);
            tick();
        end
        check16("abort_left", left_out, 16'h0000);
        check16("abort_right", right_out, 16'h0000);
        check1("abort_busy", busy, 1'b0);
        do_frame(16'h0ABC, 16'hF123, 1'b0, 1'b0, 16'h0, 1'b0);

        // Randomized frames against the reference model
        for (int n = 0; n < 24; n++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int k = 0; k < nw; k++) gain_write(16'($urandom));
            do_frame(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fx_gain_scheduler.md
Name: fx_gain_scheduler

Overview:
- Per-frame gain/mute stage between the codec interface's receive side (left_in/right_in/VALID) and its transmit side (left_out/right_out).
- Shares one signed 16x16 multiplier between the left and right channels using a fixed 3-step schedule started by each VALID strobe.
- Owns the gain configuration handshake. Gain changes take effect only at a sample-frame boundary, so no value changes mid-frame.

Parameters:
- FRAC_BITS, 14: fractional bits of the gain word (signed Q1.14).
- DEFAULT_GAIN, 16'h4000: active gain after reset (1.0).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- VALID  in  1  one-cycle strobe from the codec interface: new left_in/right_in are available.
- left_in  in  16  signed left sample.
- right_in  in  16  signed right sample.
- mute  in  1  level; when sampled 1 at frame start, that frame uses gain 0.
- gain_wr  in  1  one-cycle request to load gain_data.
- gain_data  in  16  signed Q1.14 gain.
- gain_ack  out  1  one-cycle pulse when a pending gain becomes active.
- clr_ovr  in  1  clears the overrun flag.
- left_out  out  16  processed left sample, held between frames.
- right_out  out  16  processed right sample, held between frames.
- out_vld  out  1  one-cycle pulse when left_out/right_out update.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky flag: a VALID arrived while busy.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): state IDLE; left_out=right_out=0; out_vld=gain_ack=busy=overrun=0; active_gain=DEFAULT_GAIN; pending flag cleared. Reset mid-sequence aborts the sequence and no out_vld is produced.
- Single registered 32-bit product register prod. Only one multiply is issued per cycle.
- States and transitions (E0 is the edge at which VALID=1 is sampled while in IDLE):
  - IDLE, at E0:
    - Latch l_s=left_in and r_s=right_in.
    - If pending: active_gain<=pending_gain, clear pending, gain_ack=1 in the following cycle.
    - eff_gain <= mute ? 0 : (pending ? pending_gain : active_gain).
    - Go to MUL_L.
  - MUL_L, at E1: prod<=l_s*eff_gain; go to MUL_R.
  - MUL_R, at E2: l_res<=SAT(prod); prod<=r_s*eff_gain; go to OUT.
  - OUT, at E3: left_out<=l_res; right_out<=SAT(prod); out_vld=1 for exactly the one cycle after E3; go to IDLE.
  - Latency: out_vld is high in the cycle following E3, i.e. 3 edges after VALID is sampled.
- SAT(p): arithmetic shift right by FRAC_BITS (floor, no rounding), then clamp to [-32768, 32767].
- Gain handshake:
  - gain_wr=1 stores pending_gain=gain_data and sets the pending flag.
  - Repeated writes before a frame boundary overwrite each other (last write wins) and produce a single gain_ack.
  - gain_wr on the same edge as E0: the frame uses the value pending before that edge (or active_gain if none). The new value stays pending for the next frame.
  - gain_ack never fires without a frame boundary.
- VALID while busy (states MUL_L, MUL_R, OUT):
  - The strobe is ignored and overrun is set.
  - overrun is cleared only by clr_ovr=1 or reset.
  - If set and clear occur on the same edge, set wins.
- mute is sampled only at E0. Changing mute mid-sequence has no effect on the current frame.
- Outputs hold their values between frames. busy=1 exactly in MUL_L, MUL_R and OUT.

Test Plan:
1. Reset, then VALID with L=16'h1234, R=16'hFEDC at default gain -> out_vld 3 edges later; left_out=16'h1234, right_out=16'hFEDC; gain_ack never pulses.
2. gain_wr with 16'h7FFF, then VALID with L=16'h5000, R=16'hB000 -> gain_ack pulses once; left_out=16'h7FFF, right_out=16'h8000 (saturation).
3. gain_wr with 16'h2000, VALID with L=16'h0003, R=16'hFFFD -> left_out=16'h0001, right_out=16'hFFFE (floor behaviour).
4. Two gain_wr writes (16'h1000 then 16'h4000) before one VALID, plus a gain_wr of 16'h2000 on the same edge as that VALID -> that frame uses 16'h4000 with one gain_ack; the next frame uses 16'h2000 with a second gain_ack.
5. mute=1 at a VALID with L=16'h7000 -> left_out=right_out=0. Set mute=0 one cycle later -> that frame is still 0.
6. VALID during MUL_R -> overrun=1 and the original frame completes unchanged. Then clr_ovr -> overrun=0. Separately, rst_n=0 during MUL_L -> no out_vld; outputs 0; gain back to 16'h4000.
